// File: rtl/shift_deser.sv
// shift_deser: 16-bit serial-to-parallel deserializer with mid-bit sampling and ready/valid output.
// Optional feature: define SHIFT_DESER_PARITY_EN for 17-bit frames (16 data + even parity bit).
module shift_deser #(
  parameter int F0 = 50_000_000,
  parameter int F1 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bit,
  input  logic        i_sync,
  input  logic        i_ready,
  input  logic        i_clr_ovr,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_overrun,
  output logic        o_parity_err,
  output logic        o_busy
);

  localparam int DIV = F0 / F1;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif
  // The last sample of a frame is taken straight from i_bit, so the shift
  // register only needs to hold the FRAME-1 earlier samples.
  localparam int SW = FRAME - 1;
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int BW = $clog2(FRAME);
  localparam logic [CW-1:0] C_FIRST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_BIT   = CW'(DIV - 1);
  localparam logic [BW-1:0] C_LAST  = BW'(FRAME - 1);

  if (DIV < 2) begin : g_div_check
    $error("shift_deser: F0/F1 must be at least 2");
  end

  typedef enum logic {IDLE, RECV} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_tick_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [SW-1:0]   r_shift;
  logic [15:0]     r_data;
  logic            r_valid;
  logic            r_ovr;
  logic            w_tick;
  logic            w_done;
  logic            w_load;
  logic            w_drop;
  logic [15:0]     w_word;

  // Frame start is the only transition; once receiving, framing is continuous.
  always_comb begin
    w_state_nxt = i_sync ? RECV : r_state;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A sync in the same cycle as a tick wins, so the tick is suppressed here.
  assign w_tick = (r_state == RECV) && (r_tick_cnt == '0) && !i_sync;
  assign w_done = w_tick && (r_bit_cnt == C_LAST);
  assign w_load = w_done && (!r_valid || i_ready);
  assign w_drop = w_done && !w_load;

`ifdef SHIFT_DESER_PARITY_EN
  logic r_perr;
  assign w_word = r_shift;
`else
  assign w_word = {r_shift, i_bit};
`endif

  // Mid-bit sample timer: half a bit after sync, then one bit period per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_tick_cnt <= '0;
    else if (i_sync)           r_tick_cnt <= C_FIRST;
    else if (r_state == RECV)  r_tick_cnt <= (r_tick_cnt == '0) ? C_BIT : r_tick_cnt - 1'b1;
  end

  // Bit position within the frame; wraps so the next sample opens a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_bit_cnt <= '0;
    else if (i_sync) r_bit_cnt <= '0;
    else if (w_tick) r_bit_cnt <= (r_bit_cnt == C_LAST) ? '0 : r_bit_cnt + 1'b1;
  end

  // MSB-first shift: each new sample enters at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_shift <= '0;
    else if (w_tick) r_shift <= {r_shift[SW-2:0], i_bit};
  end

  // Output word holds while valid; a completed word either loads or is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_load ? w_word : r_data;
      r_valid <= w_load || (r_valid && !i_ready);
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr <= 1'b0;
    else        r_ovr <= w_drop || (r_ovr && !i_clr_ovr);
  end

`ifdef SHIFT_DESER_PARITY_EN
  // Even parity over all 17 bits; flag travels with the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_perr <= 1'b0;
    else if (w_load) r_perr <= ^{r_shift, i_bit};
  end
  assign o_parity_err = r_perr;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;
  assign o_busy    = (r_state == RECV);

endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: vector table, hand sequences and random stimulus against a timing-arithmetic reference model.
module tb_shift_deser;

  localparam int DIV = 8;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_bit = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_clr_ovr = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_overrun;
  logic        o_parity_err;
  logic        o_busy;

  always #5 clk = ~clk;

  shift_deser #(.F0(8), .F1(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_sync(i_sync), .i_ready(i_ready),
    .i_clr_ovr(i_clr_ovr), .o_data(o_data), .o_valid(o_valid), .o_overrun(o_overrun),
    .o_parity_err(o_parity_err), .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit bq[$];

  logic [15:0] m_data;
  logic        m_valid, m_ovr, m_perr, m_recv;
  int          m_t;
  bit          m_q[$];

  typedef struct {
    logic [15:0] word;
    logic        rdy;
    logic [15:0] ed;
    logic        ev;
    logic        eo;
  } vec_t;
  vec_t tab[6];

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk16(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int cend(input int f);
    return DIV / 2 + DIV * (FRAME * (f + 1) - 1);
  endfunction

  function automatic void push_word(input logic [15:0] w, input logic pb);
    for (int i = 15; i >= 0; i--) bq.push_back(w[i]);
    if (FRAME == 17) bq.push_back(pb);
  endfunction

  function automatic void model_reset();
    m_data = '0; m_valid = 0; m_ovr = 0; m_perr = 0; m_recv = 0; m_t = 0;
    m_q.delete();
  endfunction

  // Reference: a sample falls at every elapsed time t since sync with t = DIV/2 + k*DIV.
  function automatic void model_step();
    logic hs, ld, dr, p;
    logic [15:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hs = m_valid && i_ready;
    ld = 0; dr = 0; w = '0; p = 0;
    if (i_sync) begin
      m_recv = 1; m_t = 0; m_q.delete();
    end else if (m_recv) begin
      m_t++;
      if (m_t >= DIV / 2 && (m_t - DIV / 2) % DIV == 0) begin
        m_q.push_back(i_bit);
        if (m_q.size() == FRAME) begin
          for (int i = 0; i < 16; i++) w = {w[14:0], m_q[i]};
          for (int i = 0; i < FRAME; i++) p = p ^ m_q[i];
          if (!m_valid || i_ready) ld = 1; else dr = 1;
          m_q.delete();
        end
      end
    end
    if (ld) begin
      m_data = w; m_valid = 1; m_perr = (FRAME == 17) ? p : 1'b0;
    end else if (hs) m_valid = 0;
    if (dr) m_ovr = 1; else if (i_clr_ovr) m_ovr = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk16("model_data", o_data, m_data);
    chk1("model_valid", o_valid, m_valid);
    chk1("model_overrun", o_overrun, m_ovr);
    chk1("model_parity_err", o_parity_err, m_perr);
    chk1("model_busy", o_busy, m_recv);
  endtask

  task automatic drive_one();
    int g = (cyc - 1) / DIV;
    i_bit = (g < bq.size()) ? bq[g] : 1'b0;
    tick();
    cyc++;
  endtask

  task automatic play_until(input int e);
    while (cyc <= e) drive_one();
  endtask

  task automatic send_sync();
    i_sync = 1;
    tick();
    i_sync = 0;
    cyc = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    i_sync = 0; i_clr_ovr = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  initial begin
    int nv, rises, fv;
    logic pv, bad;
    int vc[$];
    logic [15:0] vd[$];
    logic [15:0] fd;
    tab[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b1, 1'b0};
    tab[1] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
    tab[2] = '{16'hBEEF, 1'b0, 16'h1234, 1'b1, 1'b1};
    tab[3] = '{16'h0F0F, 1'b1, 16'h0F0F, 1'b1, 1'b1};
    tab[4] = '{16'h0000, 1'b0, 16'h0F0F, 1'b1, 1'b1};
    tab[5] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};

    #2 rst_n = 0;
    model_reset();
    #1;
    chk16("rst_data", o_data, 16'h0000);
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_overrun", o_overrun, 1'b0);
    chk1("rst_parity_err", o_parity_err, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    repeat (2) tick();
    rst_n = 1;

    // Continuous frames after a single sync, ready pattern from the table
    bq.delete();
    foreach (tab[f]) push_word(tab[f].word, ^tab[f].word);
    i_ready = tab[0].rdy;
    send_sync();
    foreach (tab[f]) begin
      i_ready = tab[f].rdy;
      if (f == 0) begin
        play_until(cend(0) - 1);
        chk1("valid_before_first", o_valid, 1'b0);
      end
      play_until(cend(f));
      chk16($sformatf("tab%0d_data", f), o_data, tab[f].ed);
      chk1($sformatf("tab%0d_valid", f), o_valid, tab[f].ev);
      chk1($sformatf("tab%0d_overrun", f), o_overrun, tab[f].eo);
    end
    i_clr_ovr = 1;
    drive_one();
    i_clr_ovr = 0;
    chk1("overrun_clear", o_overrun, 1'b0);

    // Back-to-back frames with ready held high
    do_reset();
    i_ready = 1;
    bq.delete();
    push_word(16'h0001, 1'b1);
    push_word(16'hFFFF, 1'b0);
    send_sync();
    nv = 0;
    while (cyc <= cend(1) + 3) begin
      drive_one();
      if (o_valid) begin
        nv++;
        vc.push_back(cyc - 1);
        vd.push_back(o_data);
      end
    end
    chki("b2b_pulses", nv, 2);
    if (vc.size() >= 2) begin
      chki("b2b_first_edge", vc[0], cend(0));
      chki("b2b_spacing", vc[1] - vc[0], 128);
      chk16("b2b_data0", vd[0], 16'h0001);
      chk16("b2b_data1", vd[1], 16'hFFFF);
    end

    // Resync after five bits discards the partial frame
    do_reset();
    i_ready = 0;
    bq.delete();
    bq.push_back(1); bq.push_back(0); bq.push_back(1); bq.push_back(1); bq.push_back(0);
    send_sync();
    play_until(DIV / 2 + DIV * 4 + 2);
    bq.delete();
    push_word(16'h5A5A, 1'b0);
    send_sync();
    rises = 0; fv = -1; fd = '0; pv = 0;
    while (cyc <= cend(0) + 20) begin
      drive_one();
      if (o_valid && !pv) begin
        rises++;
        if (fv < 0) begin
          fv = cyc - 1;
          fd = o_data;
        end
      end
      pv = o_valid;
    end
    chki("resync_rises", rises, 1);
    chki("resync_edge", fv, cend(0));
    chk16("resync_data", fd, 16'h5A5A);

    // Asynchronous reset mid-frame with a word pending, then bits without sync
    do_reset();
    i_ready = 0;
    bq.delete();
    push_word(16'hC0DE, ~^16'hC0DE);
    push_word(16'h1357, ~^16'h1357);
    send_sync();
    play_until(cend(0) + 30);
    chk1("pre_rst_valid", o_valid, 1'b1);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk16("async_rst_data", o_data, 16'h0000);
    chk1("async_rst_valid", o_valid, 1'b0);
    chk1("async_rst_busy", o_busy, 1'b0);
    chk1("async_rst_overrun", o_overrun, 1'b0);
    repeat (2) tick();
    rst_n = 1;
    bad = 0;
    repeat (200) begin
      i_bit = 1'($urandom);
      tick();
      if (o_valid || o_busy) bad = 1;
    end
    chk1("no_sync_no_valid", bad, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
    do_reset();
    i_ready = 1;
    bq.delete();
    push_word(16'h0003, 1'b0);
    push_word(16'h0007, 1'b0);
    send_sync();
    play_until(cend(0));
    chk16("par_ok_data", o_data, 16'h0003);
    chk1("par_ok_err", o_parity_err, 1'b0);
    play_until(cend(1));
    chk16("par_bad_data", o_data, 16'h0007);
    chk1("par_bad_err", o_parity_err, 1'b1);
`endif

    // Random traffic: occasional resyncs, sparse ready, rare overrun clears
    do_reset();
    send_sync();
    repeat (3000) begin
      i_sync = ($urandom_range(0, 399) == 0);
      i_bit = 1'($urandom);
      i_ready = ($urandom_range(0, 3) == 0);
      i_clr_ovr = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter F0, default 50_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter F1, default 2: serial bit rate in bits/s; DIV = F0/F1, and DIV < 2 is a compile-time error.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_bit  input  1  serial data, MSB first, each bit stable for DIV cycles.
REQ-006 SHALL have port i_sync  input  1  one-cycle frame-start strobe, coincident with the transmitter's parallel load.
REQ-007 SHALL have port i_ready  input  1  downstream accepts o_data when high with o_valid.
REQ-008 SHALL have port i_clr_ovr  input  1  clears o_overrun.
REQ-009 SHALL have port o_data  output  16  last completed word.
REQ-010 SHALL have port o_valid  output  1  o_data holds an unconsumed word.
REQ-011 SHALL have port o_overrun  output  1  sticky: a completed word was dropped.
REQ-012 SHALL have port o_parity_err  output  1  parity result for o_data (see Configuration).
REQ-013 SHALL have port o_busy  output  1  high in state RECV.

Function
REQ-014 SHALL implement states IDLE and RECV; IDLE->RECV on i_sync; RECV stays in RECV (continuous framing) until reset.
REQ-015 SHALL sample i_bit on a tick generated by an internal cycle counter: first sample DIV/2 cycles after the i_sync cycle, then every DIV cycles (mid-bit sampling).
REQ-016 SHALL, on each sample, shift i_bit into the LSB of a 16-bit internal register (MSB first) and increment the bit counter.
REQ-017 SHALL complete a frame after FRAME samples (FRAME = 16, or 17 with parity); the bit counter then returns to 0 and the next sample starts a new frame without a further i_sync.
REQ-018 SHALL, on frame completion, load o_data and set o_valid in the next cycle if o_valid is low or o_valid and i_ready are both high in the completion cycle.
REQ-019 SHALL otherwise drop the completed word, leave o_data/o_valid unchanged, and set o_overrun.
REQ-020 SHALL clear o_valid in the cycle after o_valid and i_ready are both high, unless REQ-018 reloads it in that same cycle.
REQ-021 SHALL keep o_data stable while o_valid is high.
REQ-022 SHALL, on i_sync in RECV, discard the partial frame, clear the bit counter and restart sample timing per REQ-015; o_data/o_valid unaffected.
REQ-023 SHALL give i_sync priority over a sample tick in the same cycle (the sample is ignored).
REQ-024 SHALL clear o_overrun on i_clr_ovr unless a drop occurs in the same cycle (set wins).

Reset
REQ-025 SHALL, on rst_n low, asynchronously enter IDLE and clear o_data=16'h0000, o_valid=0, o_overrun=0, o_parity_err=0, o_busy=0, bit counter and tick counter.
REQ-026 SHALL discard any partial frame on reset and require a new i_sync after release.

Configuration
REQ-027 SHALL, with macro SHIFT_DESER_PARITY_EN defined, use FRAME=17: 16 data bits then one parity bit, even parity over all 17 bits; o_parity_err=1 loaded with o_data when the check fails.
REQ-028 SHALL, without SHIFT_DESER_PARITY_EN, use FRAME=16 and drive o_parity_err constant 0.

Verification (F0=8, F1=1, DIV=8, parity off unless stated)
REQ-029 SHALL cover reset: rst_n low mid-frame -> all outputs 0 immediately, IDLE; bits without i_sync after release -> o_valid stays 0.
REQ-030 SHALL cover basic receive: i_sync at cycle 0, 0xA5C3 MSB-first, bits changing every 8 cycles from cycle 1 -> samples at cycles 4,12,...,124; o_valid=1 with o_data=16'hA5C3 at cycle 125; held until i_ready.
REQ-031 SHALL cover overrun: i_ready=0, frames 0x1234 then 0xBEEF -> o_data stays 16'h1234, o_overrun=1; i_clr_ovr pulse -> o_overrun=0.
REQ-032 SHALL cover back-to-back: i_ready=1, frames 0x0001 and 0xFFFF with one i_sync -> two one-cycle o_valid pulses, 128 cycles apart, with correct data.
REQ-033 SHALL cover resync: i_sync after 5 bits, then full 0x5A5A frame -> o_valid only once, o_data=16'h5A5A.
REQ-034 SHALL cover parity (SHIFT_DESER_PARITY_EN): 0x0003 + parity 0 -> o_parity_err=0; 0x0007 + parity 0 -> o_parity_err=1, o_data=16'h0007.
